// File: rtl/fifo_word_packer_if.sv
// Word output bus of the FIFO word packer: valid/ready handshake carrying a packed word and its byte count.
// The master side is the packer; the slave side is the downstream consumer.
interface fifo_word_packer_if #(
    parameter int BYTES = 4
);
    logic                 out_valid;
    logic                 out_ready;
    logic [8*BYTES-1:0]   out_data;
    logic [3:0]           out_bytes;

    modport master (
        output out_valid,
        output out_data,
        output out_bytes,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_bytes,
        output out_ready
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Drains a byte FIFO and packs bytes little-endian into BYTES-wide words with explicit flush of partial words.
// Optional idle-timeout auto-flush is enabled by defining FIFO_WORD_PACKER_TIMEOUT_EN.
module fifo_word_packer #(
    parameter int BYTES          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                fifo_empty,
    input  logic [7:0]          fifo_data,
    output logic                fifo_rd,
    input  logic                flush,
    fifo_word_packer_if.master  word
);
    localparam int              CNT_W = 4;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BYTES);

    if (BYTES < 2 || BYTES > 8) begin : g_bad_bytes
        $error("fifo_word_packer: BYTES must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("fifo_word_packer: TIMEOUT_CYCLES must be in 1..255");
    end

    logic [8*BYTES-1:0] asm_q;
    logic [8*BYTES-1:0] asm_wr;
    logic [CNT_W-1:0]   asm_cnt;
    logic [CNT_W-1:0]   cnt_wr;
    logic               pend;
    logic               flush_pend;
    logic               flush_req;
    logic               out_free;
    logic               full_now;
    logic               flush_emit;
    logic               flush_done;

    // cnt_wr counts captured bytes plus the one in flight, so it doubles as the read-throttle term.
    always_comb begin
        cnt_wr     = asm_cnt + {{(CNT_W-1){1'b0}}, pend};
        out_free   = !word.out_valid || word.out_ready;
        full_now   = (cnt_wr == FULL);
        fifo_rd    = !rst && !fifo_empty && !flush_pend && (cnt_wr < FULL);
        flush_emit = flush_pend && !pend && (asm_cnt != '0) && (asm_cnt < FULL) && out_free;
        flush_done = flush_pend && !pend && ((asm_cnt == '0) || out_free);
    end

    always_comb begin
        asm_wr = asm_q;
        for (int i = 0; i < BYTES; i++) begin
            if (pend && (asm_cnt == CNT_W'(i))) begin
                asm_wr[8*i +: 8] = fifo_data;
            end
        end
    end

`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
    logic [7:0] idle_cnt;
    logic       idle_inc;
    logic       timeout_hit;

    // The timeout fires on the edge the counter would reach TIMEOUT_CYCLES, acting like an external flush.
    always_comb begin
        idle_inc    = (asm_cnt != '0) && !pend && fifo_empty && !flush_pend && !flush;
        timeout_hit = idle_inc && ((idle_cnt + 8'd1) == 8'(TIMEOUT_CYCLES));
        flush_req   = flush || timeout_hit;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (!idle_inc || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end
`else
    always_comb begin
        flush_req = flush;
    end
`endif

    // Emitting a word always clears asm, so a later flushed partial word has its upper lanes zeroed.
    always_ff @(posedge clock) begin
        if (rst) begin
            word.out_valid <= 1'b0;
            word.out_data  <= '0;
            word.out_bytes <= '0;
            asm_q          <= '0;
            asm_cnt        <= '0;
            pend           <= 1'b0;
            flush_pend     <= 1'b0;
        end else begin
            pend <= fifo_rd;

            if (flush_pend) begin
                if (flush_done) begin
                    flush_pend <= 1'b0;
                end
            end else if (flush_req) begin
                flush_pend <= 1'b1;
            end

            if (full_now && out_free) begin
                word.out_data  <= asm_wr;
                word.out_bytes <= 4'(BYTES);
                word.out_valid <= 1'b1;
                asm_q          <= '0;
                asm_cnt        <= '0;
            end else if (flush_emit) begin
                word.out_data  <= asm_q;
                word.out_bytes <= asm_cnt;
                word.out_valid <= 1'b1;
                asm_q          <= '0;
                asm_cnt        <= '0;
            end else begin
                if (word.out_ready) begin
                    word.out_valid <= 1'b0;
                end
                asm_q   <= asm_wr;
                asm_cnt <= cnt_wr;
            end
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: a behavioural 32-deep byte FIFO feeds the packer, and a monitor
// pops expected words whenever a word is accepted. Build with FIFO_WORD_PACKER_TIMEOUT_EN to cover the timeout.
module tb_fifo_word_packer;
    localparam int BYTES = 4;

    typedef struct {
        logic [8*BYTES-1:0] data;
        logic [3:0]         nbytes;
    } exp_t;

    logic       clock = 1'b0;
    logic       rst;
    logic       flush;
    logic       fifo_empty;
    logic       fifo_rd;
    logic [7:0] fifo_data;
    logic       wr_en;
    logic [7:0] wr_data;

    logic [7:0] mem [32];
    logic [4:0] wp;
    logic [4:0] rp;
    int         count    = 0;
    int         rd_count = 0;
    int         rd_viol  = 0;
    int         cyc      = 0;

    int         checks   = 0;
    int         errors   = 0;
    int         accepts  = 0;
    exp_t       exp_q[$];
    exp_t       exp_head;
    int         accept_cyc[$];
    logic [7:0] stim_q[$];

    always #5 clock = ~clock;

    fifo_word_packer_if #(.BYTES(BYTES)) bus ();

    fifo_word_packer #(
        .BYTES(BYTES),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock),
        .rst(rst),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .fifo_rd(fifo_rd),
        .flush(flush),
        .word(bus.master)
    );

    // Upstream FIFO model: registered data_out, ignores rd when empty, shares the packer reset.
    assign fifo_empty = (count == 0);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            count     <= 0;
            fifo_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp      <= wp + 5'd1;
            end
            if (fifo_rd && count != 0) begin
                fifo_data <= mem[rp];
                rp        <= rp + 5'd1;
                rd_count  <= rd_count + 1;
            end
            count <= count + (wr_en ? 1 : 0) - ((fifo_rd && count != 0) ? 1 : 0);
        end
    end

    always @(negedge clock) begin
        if (fifo_rd && fifo_empty) rd_viol <= rd_viol + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: a word is taken when valid and ready are both high ahead of the next rising edge.
    always @(negedge clock) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            accepts++;
            accept_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word: got data=%h bytes=%0d, expected no word",
                         bus.out_data, bus.out_bytes);
            end else begin
                exp_head = exp_q.pop_front();
                checkOutput("word_data", 64'(bus.out_data), 64'(exp_head.data));
                checkOutput("word_bytes", 64'(bus.out_bytes), 64'(exp_head.nbytes));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus();
        while (stim_q.size() > 0) begin
            wr_data = stim_q.pop_front();
            wr_en   = 1'b1;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic pushExpected(input logic [8*BYTES-1:0] d, input logic [3:0] n);
        exp_t e;
        e.data   = d;
        e.nbytes = n;
        exp_q.push_back(e);
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int a0;
        int rd0;
        logic [31:0] w;

        rst           = 1'b1;
        flush         = 1'b0;
        wr_en         = 1'b0;
        wr_data       = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        checkOutput("reset_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_data", 64'(bus.out_data), 64'd0);
        checkOutput("reset_bytes", 64'(bus.out_bytes), 64'd0);
        checkOutput("reset_rd", 64'(fifo_rd), 64'd0);
        rst = 1'b0;
        tick();

        $display("[TB] single word");
        bus.out_ready = 1'b1;
        pushExpected(32'h44332211, 4'd4);
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus();
        waitDrain("t1_drain", 40);
        tick();
        checkOutput("t1_valid_one_cycle", 64'(bus.out_valid), 64'd0);

        $display("[TB] 32-byte stream");
        base = accept_cyc.size();
        for (int i = 0; i < 8; i++) begin
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            pushExpected(w, 4'd4);
        end
        for (int b = 0; b < 32; b++) stim_q.push_back(8'(b));
        applyStimulus();
        waitDrain("t2_drain", 200);
        if (accept_cyc.size() >= base + 8)
            checkOutput("t2_throughput_cycles", 64'(accept_cyc[base+7] - accept_cyc[base]), 64'd35);
        else
            checkOutput("t2_word_count", 64'(accept_cyc.size() - base), 64'd8);
        tick();
        checkOutput("t2_fifo_empty", 64'(fifo_empty), 64'd1);

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        rd0 = rd_count;
        pushExpected(32'h43424140, 4'd4);
        pushExpected(32'h47464544, 4'd4);
        pushExpected(32'h4B4A4948, 4'd4);
        for (int b = 0; b < 12; b++) stim_q.push_back(8'(8'h40 + b));
        applyStimulus();
        repeat (30) tick();
        checkOutput("t3_held_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("t3_held_data", 64'(bus.out_data), 64'h43424140);
        checkOutput("t3_held_bytes", 64'(bus.out_bytes), 64'd4);
        checkOutput("t3_bytes_read", 64'(rd_count - rd0), 64'd8);
        checkOutput("t3_fifo_left", 64'(count), 64'd4);
        repeat (5) tick();
        checkOutput("t3_stable_data", 64'(bus.out_data), 64'h43424140);
        bus.out_ready = 1'b1;
        waitDrain("t3_drain", 60);

        $display("[TB] flush");
        stim_q = '{8'hAA, 8'hBB};
        applyStimulus();
        repeat (5) tick();
        pushExpected(32'h0000BBAA, 4'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        waitDrain("t4_flush_drain", 20);
        a0 = accepts;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (10) tick();
        checkOutput("t4_empty_flush_words", 64'(accepts - a0), 64'd0);
        checkOutput("t4_empty_flush_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] reset mid-word");
        stim_q = '{8'hE0, 8'hE1, 8'hE2};
        applyStimulus();
        repeat (5) tick();
        checkOutput("t5_partial_no_word", 64'(bus.out_valid), 64'd0);
        rst = 1'b1;
        tick();
        checkOutput("t5_reset_bytes", 64'(bus.out_bytes), 64'd0);
        rst = 1'b0;
        tick();
        pushExpected(32'h04030201, 4'd4);
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus();
        waitDrain("t5_drain", 40);
        repeat (3) tick();

        $display("[TB] idle partial word");
        a0 = accepts;
        stim_q = '{8'h5A};
        applyStimulus();
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
        repeat (10) tick();
        checkOutput("t6_no_early_flush", 64'(accepts - a0), 64'd0);
        pushExpected(32'h0000005A, 4'd1);
        waitDrain("t6_timeout_flush", 40);
`else
        repeat (100) tick();
        checkOutput("t6_no_timeout_words", 64'(accepts - a0), 64'd0);
        checkOutput("t6_no_timeout_valid", 64'(bus.out_valid), 64'd0);
`endif

        checkOutput("rd_while_empty", 64'(rd_viol), 64'd0);
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
